mux21_rr_arbiter: RTL
=====================

# mux21_rr_arbiter

Two-requester round-robin arbiter that shares one 2:1 select datapath between requester 0 and requester 1. It accepts one word per cycle from the winning requester, drives the select, and registers the selected word into a single-entry output stage with a valid/ready handshake. It sits between two producer blocks and one downstream consumer. It replaces a free-running select with fair, lossless, back-pressured sharing.

## Interface
Parameters:
- WIDTH, 8, data width of each requester and of the output.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous and active-low. One clock; reset is synchronous and active-low.
- req  input  2  req[i] high: requester i holds a valid word on data_i.
- data0  input  WIDTH  requester 0 word.
- data1  input  WIDTH  requester 1 word.
- gnt  output  2  one-hot accept strobe. gnt[i] high: data_i is taken at this edge.
- out_data  output  WIDTH  registered selected word.
- out_valid  output  1  out_data holds a word not yet consumed.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_sel  output  1  index of the requester that supplied out_data.

## Operation
- Internal state:
  - prio (1 bit): the requester that wins a tie.
  - out stage: out_valid, out_data, out_sel.
- Load condition: load = (!out_valid | out_ready) & (req[0] | req[1]) & rst_n.
- Winner selection, combinational, only when load is high:
  - req = 01 -> winner 0.
  - req = 10 -> winner 1.
  - req = 11 -> winner = prio.
- gnt[winner] = 1 when load is high; otherwise gnt = 00. gnt is never 11.
- On a load edge:
  - out_data <= winner ? data1 : data0.
  - out_sel <= winner.
  - out_valid <= 1.
  - prio <= ~winner, even if the other requester was idle.
- Drain without load: when out_valid & out_ready and nothing is loaded, out_valid <= 0. out_data and out_sel hold their values.
- Stall: when out_valid & !out_ready, gnt = 00 and the whole out stage holds.
- Requester contract:
  - Hold req[i] and data_i stable until gnt[i] is seen.
  - May drop req[i] only after a grant.
  - The arbiter does not check this contract.
- Reset values (rst_n low at an edge): out_valid=0, out_data=0, out_sel=0, prio=0 (requester 0 wins the first tie). gnt=00 whenever rst_n is low.

## Timing
- Latency: word granted at edge N appears on out_data with out_valid=1 from edge N+1.
- Throughput: one word per cycle with out_ready held high. Simultaneous drain and load in the same cycle is required; there is no bubble.
- Both requesting continuously with out_ready high: grants alternate 0,1,0,1...
- Starvation bound: a requester holding req waits at most one other-requester transfer after the out stage can accept.
- gnt depends combinationally on req, out_valid, out_ready and rst_n. There is no combinational path from data to any control output.
- Reset mid-operation: a word in the out stage is discarded and prio returns to 0. No gnt is issued in a cycle where rst_n is low. The first load can happen in the first cycle with rst_n high.
- out_data is undefined-by-contract while out_valid=0; the bench must not check it then.

## Test plan
- Reset and idle: hold rst_n=0 for 3 cycles with req=11, then release with req=00. Required: gnt=00 throughout, out_valid=0, out_data=0, out_sel=0.
- Single requester: req=01, data0=0x5A, out_ready=1. Required: gnt=01 at the same edge; next cycle out_valid=1, out_data=0x5A, out_sel=0. Then req=10, data1=0xC3. Required: gnt=10, then out_data=0xC3, out_sel=1.
- Fair tie: req=11 for 6 cycles, data0=0x11, data1=0x22, out_ready=1. Required:
  - gnt sequence 01,10,01,10,01,10.
  - out_data 0x11,0x22,... one cycle later.
  - out_valid stays high continuously.
- Back-pressure: fill the out stage with 0x33 from requester 0, then hold out_ready=0 for 4 cycles with req=11. Required: gnt=00 and out_data=0x33 held. When out_ready=1, the same cycle gives gnt=10 (prio=1) and the next out_data is data1.
- Priority after a lone grant: grant requester 1 alone, then req=11. Required: gnt=01 first.
- Reset mid-stream: tie traffic running with prio=1 and out_valid=1; pulse rst_n=0 for one cycle. Required:
  - out_valid=0 on the next cycle.
  - The first grant after release with req=11 is gnt=01.

Source files
------------

// File: rtl/mux21_rr_arbiter.sv
// Two-requester round-robin arbiter feeding a single-entry registered output stage
// with a valid/ready handshake; the selected word is registered together with its source index.
module mux21_rr_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic [1:0]       gnt,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sel
);

    logic prio;
    logic load;
    logic winner;

    assign load = (!out_valid || out_ready) && (req[0] || req[1]) && rst_n;

    // A tie goes to prio; a lone requester always wins.
    always_comb begin
        winner = req[1] && (!req[0] || prio);
        gnt    = 2'b00;
        if (load) begin
            gnt = winner ? 2'b10 : 2'b01;
        end
    end

    // Load and drain can coincide, so a ready consumer sees no bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 1'b0;
            prio      <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= winner ? data1 : data0;
            out_sel   <= winner;
            prio      <= ~winner;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
